// File: rtl/mem_wr_burst_gen.sv
// AXI4 write burst generator: splits a byte-length command into 4 KB-safe INCR bursts,
// streams write data through, tracks outstanding responses and reports one status per command.
module mem_wr_burst_gen #(
   parameter int unsigned C0_C_S_AXI_ADDR_WIDTH = 32,
   parameter int unsigned C0_C_S_AXI_DATA_WIDTH = 512,
   parameter int unsigned C0_C_S_AXI_ID_WIDTH   = 1
) (
   input  logic                                 mem_clk,
   input  logic                                 sys_rst,
   input  logic                                 cmd_valid,
   output logic                                 cmd_ready,
   input  logic [C0_C_S_AXI_ADDR_WIDTH-1:0]     cmd_addr,
   input  logic [23:0]                          cmd_len,
   input  logic                                 s_data_tvalid,
   output logic                                 s_data_tready,
   input  logic [C0_C_S_AXI_DATA_WIDTH-1:0]     s_data_tdata,
   output logic                                 sts_valid,
   input  logic                                 sts_ready,
   output logic                                 sts_error,
   output logic [C0_C_S_AXI_ID_WIDTH-1:0]       m_axi_awid,
   output logic [C0_C_S_AXI_ADDR_WIDTH-1:0]     m_axi_awaddr,
   output logic [7:0]                           m_axi_awlen,
   output logic [2:0]                           m_axi_awsize,
   output logic [1:0]                           m_axi_awburst,
   output logic                                 m_axi_awlock,
   output logic [3:0]                           m_axi_awcache,
   output logic [2:0]                           m_axi_awprot,
   output logic                                 m_axi_awvalid,
   input  logic                                 m_axi_awready,
   output logic [C0_C_S_AXI_DATA_WIDTH-1:0]     m_axi_wdata,
   output logic [C0_C_S_AXI_DATA_WIDTH/8-1:0]   m_axi_wstrb,
   output logic                                 m_axi_wlast,
   output logic                                 m_axi_wvalid,
   input  logic                                 m_axi_wready,
   input  logic [C0_C_S_AXI_ID_WIDTH-1:0]       m_axi_bid,
   input  logic [1:0]                           m_axi_bresp,
   input  logic                                 m_axi_bvalid,
   output logic                                 m_axi_bready
);

   localparam int unsigned ADDR_W  = C0_C_S_AXI_ADDR_WIDTH;
   localparam int unsigned BEAT_W  = 18;
   localparam int unsigned BURST_W = 7;
   localparam int unsigned OUT_W   = 13;

   typedef enum logic [2:0] {S_IDLE, S_AW, S_W, S_BWAIT, S_STS} state_t;

   state_t               r_state;
   state_t               w_state_nxt;
   logic [ADDR_W-1:0]    r_addr;
   logic [BEAT_W-1:0]    r_rem;
   logic [BURST_W-1:0]   r_beat_cnt;
   logic [OUT_W-1:0]     r_outstanding;
   logic                 r_err;

   logic                 w_cmd_hs;
   logic                 w_aw_hs;
   logic                 w_w_hs;
   logic                 w_b_hs;
   logic                 w_misaligned;
   logic                 w_last_beat;
   logic [BURST_W-1:0]   w_page_beats;
   logic [BURST_W-1:0]   w_beats;
   logic [OUT_W-1:0]     w_out_nxt;
   logic                 w_unused_bid;

   // Burst size: remaining beats clipped at the next 4 KB boundary (at most 64 beats).
   assign w_page_beats = BURST_W'((13'd4096 - {1'b0, r_addr[11:0]}) >> 6);
   assign w_beats      = (r_rem < BEAT_W'(w_page_beats)) ? BURST_W'(r_rem) : w_page_beats;
   assign w_last_beat  = (r_beat_cnt == (w_beats - BURST_W'(1)));
   assign w_misaligned = (cmd_addr[5:0] != 6'd0) || (cmd_len[5:0] != 6'd0);

   assign w_cmd_hs = (r_state == S_IDLE) && cmd_valid && !sys_rst;
   assign w_aw_hs  = (r_state == S_AW) && m_axi_awready;
   assign w_w_hs   = (r_state == S_W) && s_data_tvalid && m_axi_wready;
   assign w_b_hs   = m_axi_bvalid && m_axi_bready;

   always_comb begin
      w_out_nxt = r_outstanding;
      if (w_aw_hs && !w_b_hs)      w_out_nxt = r_outstanding + OUT_W'(1);
      else if (!w_aw_hs && w_b_hs) w_out_nxt = r_outstanding - OUT_W'(1);
   end

   assign m_axi_awid    = '0;
   assign m_axi_awaddr  = r_addr;
   assign m_axi_awlen   = 8'(w_beats - BURST_W'(1));
   assign m_axi_awsize  = 3'd6;
   assign m_axi_awburst = 2'b01;
   assign m_axi_awlock  = 1'b0;
   assign m_axi_awcache = 4'b0011;
   assign m_axi_awprot  = 3'd0;
   assign m_axi_wdata   = s_data_tdata;
   assign m_axi_wstrb   = '1;
   assign m_axi_bready  = !sys_rst;
   assign w_unused_bid  = ^m_axi_bid;

   always_ff @(posedge mem_clk or posedge sys_rst) begin
      if (sys_rst) r_state <= S_IDLE;
      else         r_state <= w_state_nxt;
   end

   always_comb begin
      w_state_nxt   = r_state;
      cmd_ready     = 1'b0;
      m_axi_awvalid = 1'b0;
      m_axi_wvalid  = 1'b0;
      m_axi_wlast   = 1'b0;
      s_data_tready = 1'b0;
      sts_valid     = 1'b0;
      sts_error     = 1'b0;
      case (r_state)
         S_IDLE: begin
            cmd_ready = !sys_rst;
            if (w_cmd_hs) begin
               if (w_misaligned || (cmd_len == 24'd0)) w_state_nxt = S_STS;
               else                                    w_state_nxt = S_AW;
            end
         end
         S_AW: begin
            m_axi_awvalid = 1'b1;
            if (m_axi_awready) w_state_nxt = S_W;
         end
         S_W: begin
            m_axi_wvalid  = s_data_tvalid;
            s_data_tready = m_axi_wready;
            m_axi_wlast   = w_last_beat;
            if (w_w_hs && w_last_beat)
               w_state_nxt = (r_rem != BEAT_W'(w_beats)) ? S_AW : S_BWAIT;
         end
         S_BWAIT: begin
            if (w_out_nxt == OUT_W'(0)) w_state_nxt = S_STS;
         end
         S_STS: begin
            sts_valid = 1'b1;
            sts_error = r_err;
            if (sts_ready) w_state_nxt = S_IDLE;
         end
         default: w_state_nxt = S_IDLE;
      endcase
   end

   // Command address/length bookkeeping, beat counter, response tracking.
   always_ff @(posedge mem_clk or posedge sys_rst) begin
      if (sys_rst) begin
         r_addr        <= '0;
         r_rem         <= '0;
         r_beat_cnt    <= '0;
         r_outstanding <= '0;
         r_err         <= 1'b0;
      end else begin
         r_outstanding <= w_out_nxt;
         if (w_cmd_hs) begin
            r_addr     <= cmd_addr;
            r_rem      <= cmd_len[23:6];
            r_beat_cnt <= '0;
            r_err      <= w_misaligned;
         end else begin
            if (w_b_hs && (m_axi_bresp != 2'b00)) r_err <= 1'b1;
            if (w_w_hs) begin
               if (w_last_beat) begin
                  r_addr     <= r_addr + ADDR_W'({w_beats, 6'b0});
                  r_rem      <= r_rem - BEAT_W'(w_beats);
                  r_beat_cnt <= '0;
               end else begin
                  r_beat_cnt <= r_beat_cnt + BURST_W'(1);
               end
            end
         end
      end
   end

endmodule

// File: doc/mem_wr_burst_gen.md
MEM_WR_BURST_GEN -- requirements
Module: mem_wr_burst_gen

Interface
REQ-001 SHALL have parameter C0_C_S_AXI_ADDR_WIDTH, default 32, AXI address width.
REQ-002 SHALL have parameter C0_C_S_AXI_DATA_WIDTH, default 512, data width; one beat is 64 bytes.
REQ-003 SHALL have parameter C0_C_S_AXI_ID_WIDTH, default 1, AXI ID width.
REQ-004 SHALL use one clock and an asynchronous, active-high reset:
- mem_clk  in  1  clock for all logic
- sys_rst  in  1  asynchronous, active-high reset
REQ-005 SHALL have the command and data ports:
- cmd_valid / cmd_ready  in / out  1  command handshake
- cmd_addr  in  ADDR_WIDTH  start byte address
- cmd_len  in  24  length in bytes
- s_data_tvalid / s_data_tready  in / out  1  write data handshake
- s_data_tdata  in  DATA_WIDTH  write data beat
REQ-006 SHALL have the status ports:
- sts_valid / sts_ready  out / in  1  status handshake
- sts_error  out  1  1 = command failed
REQ-007 SHALL have the AXI4 write master ports feeding the DDR4 controller slave:
- m_axi_awid  out  ID_WIDTH
- m_axi_awaddr  out  ADDR_WIDTH
- m_axi_awlen  out  8
- m_axi_awsize  out  3
- m_axi_awburst  out  2
- m_axi_awlock/awcache/awprot  out  1/4/3
- m_axi_awvalid  out  1;  m_axi_awready  in  1
- m_axi_wdata  out  DATA_WIDTH;  m_axi_wstrb  out  DATA_WIDTH/8
- m_axi_wlast / m_axi_wvalid  out  1;  m_axi_wready  in  1
- m_axi_bid  in  ID_WIDTH;  m_axi_bresp  in  2;  m_axi_bvalid  in  1;  m_axi_bready  out  1

Function
REQ-008 SHALL drive these constants: awid=0, awsize=3'd6, awburst=2'b01 (INCR), awlock=0, awcache=4'b0011, awprot=0, wstrb all ones.
REQ-009 SHALL implement FSM states IDLE, AW, W, BWAIT, STS.
REQ-010 SHALL assert cmd_ready only in IDLE and SHALL capture addr and len on the cmd handshake.
REQ-011 On accept, IDLE SHALL transition as follows:
- cmd_addr[5:0]!=0 or cmd_len[5:0]!=0 -> STS with error=1; no AXI traffic, no data consumed.
- cmd_len==0 -> STS with error=0.
- otherwise -> AW, with remaining beats = cmd_len>>6.
REQ-012 Burst beats SHALL equal min(remaining, (4096-addr[11:0])>>6), so a burst never crosses 4 KB and is never more than 64 beats; awlen = beats-1.
REQ-013 In AW, awvalid SHALL be asserted with awaddr/awlen held stable until the awready handshake; the FSM then goes to W.
REQ-014 In W:
- wvalid = s_data_tvalid; s_data_tready = wready; wdata = tdata.
- Outside W, s_data_tready and wvalid SHALL be 0.
REQ-015 wlast SHALL be 1 exactly on beat index beats-1. On that handshake, addr += beats*64 and remaining -= beats; the FSM goes to AW if remaining>0, else to BWAIT.
REQ-016 An outstanding counter (13 bits) SHALL increment on each AW handshake and decrement on each B handshake; simultaneous events leave it unchanged.
REQ-017 bready SHALL be 1 whenever not in reset; B responses MAY arrive during AW/W.
REQ-018 Any bresp!=2'b00 SHALL set a sticky error flag, cleared on the next cmd accept.
REQ-019 BWAIT SHALL go to STS when outstanding==0.
REQ-020 STS SHALL hold sts_valid=1 and sts_error until sts_ready, then return to IDLE.
REQ-021 Latency: awvalid SHALL assert the cycle after cmd accept; sts_valid SHALL assert the cycle after the final B handshake, or the cycle after accept for zero/misaligned commands.

Reset
REQ-022 While sys_rst=1, all of the following SHALL be 0 asynchronously: cmd_ready, s_data_tready, sts_valid, sts_error, awvalid, wvalid, wlast, bready, the counters, and the error flag. The FSM SHALL be in IDLE.
REQ-023 Reset mid-operation SHALL abandon the command with no status; the downstream controller is reset from the same domain.

Verification
REQ-024 addr 0x0000_1000, len 4096 -> one AW (awaddr 0x1000, awlen 63), 64 W beats with wlast on the 64th, then sts_error=0.
REQ-025 addr 0x0000_0FC0, len 256 -> AW 0xFC0/awlen 0, then AW 0x1000/awlen 2; 4 W beats total; status only after both B handshakes.
REQ-026 bresp=2'b10 on the first of two bursts -> both bursts complete and sts_error=1; the next good command reports 0.
REQ-027 len 0 -> sts_valid the cycle after accept, no AW; addr 0x20 len 64 -> sts_error=1, no AW, s_data_tready stays 0.
REQ-028 awready low 5 cycles and tvalid gaps -> awaddr/awlen stable throughout, wvalid mirrors tvalid, beat count exact.
REQ-029 sys_rst pulsed on beat 10 of 64 -> all valids 0 within the same cycle, FSM IDLE, cmd_ready=1 after release.
